fifo_burst_reader: RTL
======================

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter: NBITS, 16, data word width; equals the width of the upstream FIFO.
REQ-002 SHALL have parameter: CNT_WIDTH, 8, burst-length counter width.
REQ-003 SHALL have port: clk  in  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: start  in  1  burst request; sampled only in IDLE.
REQ-006 SHALL have port: len  in  CNT_WIDTH  number of words in the burst; sampled with start.
REQ-007 SHALL have port: busy  out  1  high in RUN and FLUSH.
REQ-008 SHALL have port: done  out  1  one-cycle completion pulse.
REQ-009 SHALL have port: fifo_empty  in  1  upstream FIFO empty flag.
REQ-010 SHALL have port: fifo_q  in  NBITS  upstream FIFO read data, valid combinationally in the same cycle as fifo_ren & ~fifo_empty.
REQ-011 SHALL have port: fifo_ren  out  1  upstream FIFO pop.
REQ-012 SHALL have port: out_valid  out  1  downstream word valid.
REQ-013 SHALL have port: out_data  out  NBITS  downstream word.
REQ-014 SHALL have port: out_last  out  1  marks the final word of the burst.
REQ-015 SHALL have port: out_ready  in  1  downstream accept; a transfer occurs when out_valid & out_ready.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, FLUSH, DONE.
REQ-017 IDLE: on start with len!=0, SHALL latch len into remaining and go to RUN; on start with len==0, SHALL go to DONE with no FIFO reads.
REQ-018 SHALL assert fifo_ren = (state==RUN) & (remaining!=0) & ~fifo_empty & (~out_valid | out_ready), and SHALL never assert fifo_ren while fifo_empty=1.
REQ-019 On each fifo_ren cycle, SHALL register fifo_q into out_data, set out_valid=1 next cycle, and decrement remaining by 1.
REQ-020 out_last SHALL be registered as 1 together with the word popped when remaining==1, and 0 otherwise.
REQ-021 Read latency SHALL be 1 cycle: fifo_ren in cycle N gives out_valid in cycle N+1.
REQ-022 Throughput SHALL be 1 word/cycle while out_ready=1 and fifo_empty=0.
REQ-023 While out_valid & ~out_ready, out_data and out_last SHALL hold stable and fifo_ren SHALL be 0.
REQ-024 out_valid SHALL clear after a transfer that is not accompanied by a new pop in the same cycle.
REQ-025 RUN SHALL go to FLUSH in the cycle remaining reaches 0, i.e. the last pop.
REQ-026 FLUSH SHALL go to DONE on the transfer with out_last=1.
REQ-027 DONE SHALL assert done=1 for exactly one cycle and then go unconditionally to IDLE.
REQ-028 start SHALL be ignored in RUN, FLUSH and DONE; len changes outside an accepted start SHALL have no effect.
REQ-029 An empty FIFO mid-burst SHALL stall reads, with busy held, out_valid draining normally, and no timeout.
REQ-030 len=2^CNT_WIDTH-1 SHALL be supported; remaining SHALL not wrap below 0.

Reset
REQ-031 rst=0 SHALL asynchronously force state=IDLE, remaining=0, out_valid=0, out_data=0, out_last=0, done=0, busy=0, fifo_ren=0.
REQ-032 Reset asserted mid-burst SHALL abandon the burst with no done pulse; the unread FIFO contents are the upstream owner's concern.
REQ-033 After rst deasserts, the first start SHALL be accepted on the first clk edge.

Structure
REQ-034 The state enum (feeder_state_t: IDLE, RUN, FLUSH, DONE) and the default NBITS constant SHALL live in the shared npu_pkg package.
REQ-035 SHALL be a single module with no sub-module; the output register and counter SHALL be inline.

Verification
REQ-036 FIFO preloaded with 0x0001..0x0004, len=4, out_ready=1 -> 4 consecutive transfers 0x0001..0x0004, out_last only on 0x0004, done 1 cycle after the last transfer.
REQ-037 len=3, out_ready toggling 1,0,0,1,... -> data held stable during stalls, fifo_ren=0 while stalled, 3 transfers in order.
REQ-038 FIFO empty at start, len=2, words written 5 cycles later -> fifo_ren=0 while empty, busy=1 throughout, 2 transfers after the writes.
REQ-039 start with len=0 -> done pulse 1 cycle later, fifo_ren never asserted, busy never asserted.
REQ-040 rst=0 mid-burst of len=4 after 2 transfers -> all outputs 0 immediately, no done pulse; new start with len=1 completes normally.
REQ-041 start asserted during RUN with a different len -> ignored; the original burst count is delivered.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared types and defaults for the NPU datapath feeders.
package npu_pkg;

  localparam int NBITS_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/fifo_burst_reader.sv
// Pops a fixed-length burst from an upstream FIFO into a one-deep valid/ready output register.
//
// state | meaning
// IDLE  | waiting for start; len latched on accept
// RUN   | popping words while remaining != 0
// FLUSH | last word popped, waiting for its transfer
// DONE  | one-cycle done pulse, then back to IDLE
module fifo_burst_reader
  import npu_pkg::*;
#(
  parameter int NBITS     = NBITS_DEFAULT,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] len,
  output logic                 busy,
  output logic                 done,
  input  logic                 fifo_empty,
  input  logic [NBITS-1:0]     fifo_q,
  output logic                 fifo_ren,
  output logic                 out_valid,
  output logic [NBITS-1:0]     out_data,
  output logic                 out_last,
  input  logic                 out_ready
);

  feeder_state_t        state, state_nxt;
  logic [CNT_WIDTH-1:0] remaining;
  logic                 xfer;
  logic                 last_pop;

  assign xfer     = out_valid & out_ready;
  assign last_pop = (remaining == CNT_WIDTH'(1));

  // A pop is only allowed when the output register is free or being emptied this cycle.
  assign fifo_ren = (state == RUN) && (remaining != '0) && !fifo_empty &&
                    (!out_valid || out_ready);

  assign busy = (state == RUN) || (state == FLUSH);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (fifo_ren && last_pop) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (xfer && out_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining <= '0;
    end else if ((state == IDLE) && start) begin
      remaining <= len;
    end else if (fifo_ren) begin
      remaining <= remaining - CNT_WIDTH'(1);
    end
  end

  // Output register holds data and last while stalled; a pop overwrites it in the same cycle as a transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (fifo_ren) begin
      out_valid <= 1'b1;
      out_data  <= fifo_q;
      out_last  <= last_pop;
    end else if (xfer) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule
